note_judge: RTL and testbench

//  Player-input side of the note lane. The square10/square4x4 path draws the red/yellow note

---
 rtl/note_judge_pkg.sv | 15 +
 rtl/note_judge_key_edge_sync.sv | 27 ++
 rtl/note_judge.sv | 175 +++++++++++++++++
 tb/tb_note_judge.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_judge_pkg.sv
// Shared encodings for the note lane judge: FSM states and verdict codes.
package note_judge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] JUDGE_NONE  = 2'b00;
    localparam logic [1:0] JUDGE_GOOD  = 2'b01;
    localparam logic [1:0] JUDGE_MISS  = 2'b10;
    localparam logic [1:0] JUDGE_WRONG = 2'b11;

endpackage

// File: rtl/note_judge_key_edge_sync.sv
// Two-flop synchroniser for an asynchronous drum key followed by a registered rising-edge pulse.
module key_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic rise_o
);

    logic sync1_q, sync2_q, last_q, rise_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            rise_q  <= sync2_q & ~last_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/note_judge.sv
// Judges drum-key presses against the note on the hit line; keeps score, combo and peak combo.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int NOTES       = 10,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int POINTS_GOOD = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       beat_tick,
    input  logic [NOTES-1:0]           red_sequence,
    input  logic [NOTES-1:0]           yellow_sequence,
    input  logic                       key_red,
    input  logic                       key_yellow,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NOTES+1)-1:0] note_index,
    output logic                       judge_valid,
    output logic [1:0]                 judge_code,
    output logic [SCORE_W-1:0]         score,
    output logic [COMBO_W-1:0]         combo,
    output logic [COMBO_W-1:0]         max_combo
);

    localparam int IDX_W = $clog2(NOTES+1);

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] a);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W+1)'(POINTS_GOOD);
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_inc(input logic [COMBO_W-1:0] a);
        return (a == {COMBO_W{1'b1}}) ? a : a + 1'b1;
    endfunction

    logic red_rise, yel_rise;

    key_edge_sync u_red_sync (
        .clk    (clk),
        .reset  (reset),
        .key_i  (key_red),
        .rise_o (red_rise)
    );

    key_edge_sync u_yel_sync (
        .clk    (clk),
        .reset  (reset),
        .key_i  (key_yellow),
        .rise_o (yel_rise)
    );

    state_t             state_q, state_d;
    logic [NOTES-1:0]   red_sr_q, red_sr_d, yel_sr_q, yel_sr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               judged_q, judged_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d, max_q, max_d;
    logic               jv_q, jv_d;
    logic [1:0]         jc_q, jc_d;

    logic               key_ev, good;
    logic [COMBO_W-1:0] combo_inc;

    always_comb begin
        state_d   = state_q;
        red_sr_d  = red_sr_q;
        yel_sr_d  = yel_sr_q;
        idx_d     = idx_q;
        judged_d  = judged_q;
        score_d   = score_q;
        combo_d   = combo_q;
        max_d     = max_q;
        jv_d      = 1'b0;
        jc_d      = jc_q;
        key_ev    = 1'b0;
        good      = 1'b0;
        combo_inc = sat_inc(combo_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_PLAY;
                    red_sr_d = red_sequence;
                    yel_sr_d = yellow_sequence;
                    idx_d    = '0;
                    judged_d = 1'b0;
                    score_d  = '0;
                    combo_d  = '0;
                    max_d    = '0;
                end
            end
            ST_PLAY: begin
                // Red wins a same-cycle double press; a red+yellow slot counts as red only.
                if (red_rise) begin
                    key_ev = 1'b1;
                    good   = red_sr_q[0] & ~judged_q;
                end else if (yel_rise) begin
                    key_ev = 1'b1;
                    good   = yel_sr_q[0] & ~red_sr_q[0] & ~judged_q;
                end

                if (key_ev) begin
                    jv_d = 1'b1;
                    if (good) begin
                        jc_d     = JUDGE_GOOD;
                        score_d  = sat_score(score_q);
                        combo_d  = combo_inc;
                        judged_d = 1'b1;
                        if (combo_inc > max_q) max_d = combo_inc;
                    end else begin
                        jc_d    = JUDGE_WRONG;
                        combo_d = '0;
                    end
                end

                // The key above was judged against the pre-shift slot; a GOOD there cancels the MISS.
                if (beat_tick) begin
                    if ((red_sr_q[0] | yel_sr_q[0]) & ~judged_q & ~good) begin
                        combo_d = '0;
                        if (!key_ev) begin
                            jv_d = 1'b1;
                            jc_d = JUDGE_MISS;
                        end
                    end
                    red_sr_d = {1'b0, red_sr_q[NOTES-1:1]};
                    yel_sr_d = {1'b0, yel_sr_q[NOTES-1:1]};
                    idx_d    = idx_q + 1'b1;
                    judged_d = 1'b0;
                    if (idx_q == IDX_W'(NOTES-1)) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            red_sr_q <= '0;
            yel_sr_q <= '0;
            idx_q    <= '0;
            judged_q <= 1'b0;
            score_q  <= '0;
            combo_q  <= '0;
            max_q    <= '0;
            jv_q     <= 1'b0;
            jc_q     <= JUDGE_NONE;
        end else begin
            state_q  <= state_d;
            red_sr_q <= red_sr_d;
            yel_sr_q <= yel_sr_d;
            idx_q    <= idx_d;
            judged_q <= judged_d;
            score_q  <= score_d;
            combo_q  <= combo_d;
            max_q    <= max_d;
            jv_q     <= jv_d;
            jc_q     <= jc_d;
        end
    end

    assign busy        = (state_q == ST_PLAY);
    assign done        = (state_q == ST_DONE);
    assign note_index  = idx_q;
    assign judge_valid = jv_q;
    assign judge_code  = jc_q;
    assign score       = score_q;
    assign combo       = combo_q;
    assign max_combo   = max_q;

endmodule

// File: tb/tb_note_judge.sv
// Scoreboard bench for note_judge: expected verdicts are queued at stimulus time, checked on judge_valid.
module tb_note_judge;

    localparam int NOTES = 10;
    localparam int SW    = 16;
    localparam int CW    = 8;

    localparam logic [1:0] C_GOOD  = 2'b01;
    localparam logic [1:0] C_MISS  = 2'b10;
    localparam logic [1:0] C_WRONG = 2'b11;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             beat_tick = 1'b0;
    logic [NOTES-1:0] red_sequence = '0;
    logic [NOTES-1:0] yellow_sequence = '0;
    logic             key_red = 1'b0;
    logic             key_yellow = 1'b0;
    logic             busy, done, judge_valid;
    logic [3:0]       note_index;
    logic [1:0]       judge_code;
    logic [SW-1:0]    score;
    logic [CW-1:0]    combo, max_combo;

    note_judge #(.NOTES(NOTES), .SCORE_W(SW), .COMBO_W(CW), .POINTS_GOOD(10)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .beat_tick       (beat_tick),
        .red_sequence    (red_sequence),
        .yellow_sequence (yellow_sequence),
        .key_red         (key_red),
        .key_yellow      (key_yellow),
        .busy            (busy),
        .done            (done),
        .note_index      (note_index),
        .judge_valid     (judge_valid),
        .judge_code      (judge_code),
        .score           (score),
        .combo           (combo),
        .max_combo       (max_combo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    code;
        logic [SW-1:0] score;
        logic [CW-1:0] combo;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_score, m_combo, m_max;

    always @(negedge clk) begin
        if (judge_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_judge: got code=%b score=%0d combo=%0d, required no judge",
                         judge_code, score, combo);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({judge_code, score, combo} !== {e.code, e.score, e.combo}) begin
                    miscompares++;
                    $display("FAIL judge: got code=%b score=%0d combo=%0d, required code=%b score=%0d combo=%0d",
                             judge_code, score, combo, e.code, e.score, e.combo);
                end
            end
        end
    end

    task automatic expect_j(input logic [1:0] code);
        exp_t e;
        if (code == C_GOOD) begin
            m_score += 10;
            m_combo += 1;
            if (m_combo > m_max) m_max = m_combo;
        end else begin
            m_combo = 0;
        end
        e.code  = code;
        e.score = SW'(m_score);
        e.combo = CW'(m_combo);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic tick);
        beat_tick = tick;
        @(posedge clk);
        #1;
        beat_tick = 1'b0;
    endtask

    // Raise keys and wait until the synchronised edge is presented to the judge on the next edge.
    task automatic press(input logic r, input logic y);
        key_red    = r;
        key_yellow = y;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_keys();
        key_red    = 1'b0;
        key_yellow = 1'b0;
        repeat (3) step(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_red = 1'b0;
        key_yellow = 1'b0;
        start = 1'b0;
        beat_tick = 1'b0;
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
        exp_q.delete();
        m_score = 0;
        m_combo = 0;
        m_max = 0;
    endtask

    task automatic do_start(input logic [NOTES-1:0] r, input logic [NOTES-1:0] y);
        red_sequence    = r;
        yellow_sequence = y;
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        m_score = 0;
        m_combo = 0;
        m_max = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pending: got %0d judges outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({busy, done, note_index, judge_valid, judge_code, score, combo, max_combo} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b idx=%0d jv=%b jc=%b score=%0d combo=%0d max=%0d, required all 0",
                     busy, done, note_index, judge_valid, judge_code, score, combo, max_combo);
        end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        do_start(10'b0000000111, '0);
        for (int i = 0; i < 3; i++) begin
            press(1'b1, 1'b0);
            expect_j(C_GOOD);
            step(1'b0);
            release_keys();
            step(1'b1);
        end
        drain("midplay");
        vectors++;
        if (score !== 16'd30 || combo !== 8'd3) begin
            miscompares++;
            $display("FAIL midplay_setup: got score=%0d combo=%0d, required 30 3", score, combo);
        end
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        vectors++;
        if ({busy, score, combo, judge_valid} !== '0) begin
            miscompares++;
            $display("FAIL midplay_reset: got busy=%b score=%0d combo=%0d jv=%b, required 0 0 0 0",
                     busy, score, combo, judge_valid);
        end
    endtask

    task automatic test_good();
        do_reset();
        do_start(10'b0000000001, '0);
        vectors++;
        if (busy !== 1'b1 || note_index !== 4'd0) begin
            miscompares++;
            $display("FAIL good_start: got busy=%b idx=%0d, required 1 0", busy, note_index);
        end
        press(1'b1, 1'b0);
        expect_j(C_GOOD);
        step(1'b0);
        release_keys();
        step(1'b1);
        step(1'b0);
        drain("good");
        vectors++;
        if (score !== 16'd10 || combo !== 8'd1 || note_index !== 4'd1) begin
            miscompares++;
            $display("FAIL good_after_tick: got score=%0d combo=%0d idx=%0d, required 10 1 1",
                     score, combo, note_index);
        end
    endtask

    task automatic test_miss();
        do_reset();
        do_start(10'b0000000011, '0);
        expect_j(C_MISS);
        step(1'b1);
        expect_j(C_MISS);
        step(1'b1);
        step(1'b0);
        drain("miss");
        vectors++;
        if (score !== 16'd0 || combo !== 8'd0 || note_index !== 4'd2) begin
            miscompares++;
            $display("FAIL miss_state: got score=%0d combo=%0d idx=%0d, required 0 0 2",
                     score, combo, note_index);
        end
    endtask

    task automatic test_wrong();
        do_reset();
        do_start('0, 10'b0000000001);
        press(1'b1, 1'b0);
        expect_j(C_WRONG);
        step(1'b0);
        release_keys();
        press(1'b0, 1'b1);
        expect_j(C_GOOD);
        step(1'b0);
        release_keys();
        press(1'b0, 1'b1);
        expect_j(C_WRONG);
        step(1'b0);
        release_keys();
        drain("wrong");
        vectors++;
        if (score !== 16'd10 || combo !== 8'd0) begin
            miscompares++;
            $display("FAIL wrong_state: got score=%0d combo=%0d, required 10 0", score, combo);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        do_start(10'b0000000011, 10'b0000000010);
        press(1'b1, 1'b0);
        expect_j(C_GOOD);
        step(1'b1);
        release_keys();
        vectors++;
        if (note_index !== 4'd1) begin
            miscompares++;
            $display("FAIL coincident_index: got %0d, required 1", note_index);
        end
        press(1'b1, 1'b1);
        expect_j(C_GOOD);
        step(1'b0);
        release_keys();
        step(1'b1);
        step(1'b0);
        drain("coincident");
        vectors++;
        if (score !== 16'd20 || combo !== 8'd2 || max_combo !== 8'd2) begin
            miscompares++;
            $display("FAIL coincident_state: got score=%0d combo=%0d max=%0d, required 20 2 2",
                     score, combo, max_combo);
        end
    endtask

    task automatic test_full_song();
        do_reset();
        do_start(10'b1111111111, '0);
        for (int i = 0; i < NOTES; i++) begin
            press(1'b1, 1'b0);
            expect_j(C_GOOD);
            step(1'b0);
            release_keys();
            step(1'b1);
        end
        drain("song");
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || score !== 16'd100 || max_combo !== 8'd10 || note_index !== 4'd10) begin
            miscompares++;
            $display("FAIL song_end: got done=%b busy=%b score=%0d max=%0d idx=%0d, required 1 0 100 10 10",
                     done, busy, score, max_combo, note_index);
        end
        press(1'b1, 1'b0);
        step(1'b1);
        release_keys();
        step(1'b1);
        vectors++;
        if (done !== 1'b1 || score !== 16'd100 || combo !== 8'd10 || note_index !== 4'd10) begin
            miscompares++;
            $display("FAIL done_idle: got done=%b score=%0d combo=%0d idx=%0d, required 1 100 10 10",
                     done, score, combo, note_index);
        end
        do_start(10'b1111111111, '0);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || score !== 16'd0 || max_combo !== 8'd0 || note_index !== 4'd0) begin
            miscompares++;
            $display("FAIL restart: got busy=%b done=%b score=%0d max=%0d idx=%0d, required 1 0 0 0 0",
                     busy, done, score, max_combo, note_index);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_play();
        test_good();
        test_miss();
        test_wrong();
        test_coincident();
        test_full_song();
        repeat (4) step(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
